// File: rtl/spell_stack_if.sv
// spell_stack_if: executor op port, wishbone debug port and stack
// status outputs of the spell stack, bundled as one interface.
interface spell_stack_if #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 5
);
    logic                  op_valid;
    logic                  op_ready;
    logic [1:0]            op_pop;
    logic [1:0]            op_push;
    logic [WIDTH-1:0]      op_top;
    logic [WIDTH-1:0]      op_below;
    logic [WIDTH-1:0]      top;
    logic [WIDTH-1:0]      below;
    logic [DEPTH_LOG2:0]   sp;
    logic                  op_error;
    logic                  i_wb_cyc;
    logic                  i_wb_stb;
    logic                  i_wb_we;
    logic [31:0]           i_wb_addr;
    logic [31:0]           i_wb_data;
    logic                  o_wb_ack;
    logic [31:0]           o_wb_data;
    logic                  interrupt;

    modport master (
        output op_valid, op_pop, op_push, op_top, op_below,
        output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
        input  op_ready, top, below, sp, op_error,
        input  o_wb_ack, o_wb_data, interrupt
    );

    modport slave (
        input  op_valid, op_pop, op_push, op_top, op_below,
        input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
        output op_ready, top, below, sp, op_error,
        output o_wb_ack, o_wb_data, interrupt
    );
endinterface

// File: rtl/spell_stack.sv
// spell_stack: parametrised data stack with occupancy tracking, overflow/
// underflow interrupts and a wishbone debug port. Macro SPELL_STACK_PEEK_EN
// enables the 0x100 peek window into the stack.
module spell_stack #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 5
) (
    input logic          clock,
    input logic          reset,
    spell_stack_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int SPW   = DEPTH_LOG2 + 1;
    localparam int NW    = DEPTH_LOG2 + 2;
    localparam int AW    = DEPTH_LOG2;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [SPW-1:0]   sp_q;
    logic [1:0]       intr_q;
    logic [1:0]       ien_q;
    logic             ack_q;
    logic             err_q;
    logic             req_q;
    logic [31:0]      rdata_q;

    logic             req, wr, rd, first;
    logic [11:0]      addr;
    logic             a_sp, a_top, a_push, a_pop;
    logic             a_stat, a_ien, a_int;
    logic             peek_hit;
    logic [AW-1:0]    peek_idx;
    logic             full, empty;
    logic [SPW-1:0]   spm1, spm2;
    logic [WIDTH-1:0] top_w, below_w;
    logic [NW-1:0]    n, nm1, nm2;
    logic             under, over;
    logic             op_go, op_ok;
    logic [1:0]       int_set, int_clr;
    logic [31:0]      rd_val;
    logic             unused_ok;

    assign req    = bus.i_wb_cyc & bus.i_wb_stb;
    assign wr     = req & bus.i_wb_we;
    assign rd     = req & ~bus.i_wb_we;
    assign first  = req & ~req_q;
    assign addr   = bus.i_wb_addr[11:0];
    assign a_sp   = addr == 12'h000;
    assign a_top  = addr == 12'h004;
    assign a_push = addr == 12'h008;
    assign a_pop  = addr == 12'h00C;
    assign a_stat = addr == 12'h010;
    assign a_ien  = addr == 12'h014;
    assign a_int  = addr == 12'h018;

    assign full    = sp_q == SPW'(DEPTH);
    assign empty   = sp_q == '0;
    assign spm1    = sp_q - SPW'(1);
    assign spm2    = sp_q - SPW'(2);
    assign top_w   = empty ? '0 : mem[spm1[AW-1:0]];
    assign below_w = (sp_q < SPW'(2)) ? '0 : mem[spm2[AW-1:0]];

`ifdef SPELL_STACK_PEEK_EN
    logic [11:0]    poff;
    logic [SPW-1:0] pi;
    logic [SPW-1:0] pidx;
    assign poff     = addr - 12'h100;
    assign pi       = SPW'(poff[11:2]);
    assign pidx     = sp_q - SPW'(1) - pi;
    assign peek_hit = (addr >= 12'h100) && (poff[11:2] < 10'(DEPTH))
                      && (poff[1:0] == 2'b00) && (pi < sp_q);
    assign peek_idx = pidx[AW-1:0];
`else
    assign peek_hit = 1'b0;
    assign peek_idx = '0;
`endif

    // n is signed so a pop deeper than sp shows up negative
    assign n     = NW'(sp_q) - NW'(bus.op_pop) + NW'(bus.op_push);
    assign nm1   = n - NW'(1);
    assign nm2   = n - NW'(2);
    assign under = SPW'(bus.op_pop) > sp_q;
    assign over  = $signed(n) > $signed(NW'(DEPTH));

    // a POP read also moves sp, so it stalls the executor on its first cycle
    assign bus.op_ready = ~wr & ~(rd & first & a_pop);
    assign op_go        = bus.op_valid & bus.op_ready;
    assign op_ok        = op_go & ~under & ~over;

    assign int_set[0] = (op_go & under) | (rd & first & a_pop & empty);
    assign int_set[1] = (op_go & ~under & over) | (wr & first & a_push & full);
    assign int_clr    = (wr & a_int) ? bus.i_wb_data[1:0] : 2'b00;

    assign bus.top       = top_w;
    assign bus.below     = below_w;
    assign bus.sp        = sp_q;
    assign bus.op_error  = err_q;
    assign bus.o_wb_ack  = ack_q;
    assign bus.o_wb_data = rdata_q;
    assign bus.interrupt = |(intr_q & ien_q);
    assign unused_ok     = &{1'b0, bus.i_wb_addr[31:12]};

    // wishbone read data mux
    always_comb begin
        rd_val = '0;
        unique case (1'b1)
            a_sp:         rd_val = 32'(sp_q);
            a_top, a_pop: rd_val = 32'(top_w);
            a_stat:       rd_val = {full, empty, 30'(sp_q)};
            a_ien:        rd_val = 32'(ien_q);
            a_int:        rd_val = 32'(intr_q);
            peek_hit:     rd_val = 32'(mem[peek_idx]);
            default:      rd_val = '0;
        endcase
    end

    // stack storage, occupancy, interrupts and bus response registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            sp_q    <= '0;
            intr_q  <= '0;
            ien_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            ack_q  <= req;
            req_q  <= req;
            err_q  <= op_go & (under | over);
            intr_q <= (intr_q & ~int_clr) | int_set;
            if (rd && first) rdata_q <= rd_val;
            if (rd && first && a_pop && !empty) sp_q <= spm1;
            if (op_ok) begin
                sp_q <= n[SPW-1:0];
                if (bus.op_push != 2'd0) mem[nm1[AW-1:0]] <= bus.op_top;
                if (bus.op_push == 2'd2) mem[nm2[AW-1:0]] <= bus.op_below;
            end
            if (wr) begin
                unique case (1'b1)
                    a_sp: begin
                        if (bus.i_wb_data > 32'(DEPTH)) sp_q <= SPW'(DEPTH);
                        else sp_q <= bus.i_wb_data[SPW-1:0];
                    end
                    a_top: begin
                        if (!empty)
                            mem[spm1[AW-1:0]] <= bus.i_wb_data[WIDTH-1:0];
                    end
                    a_push: begin
                        if (first && !full) begin
                            mem[sp_q[AW-1:0]] <= bus.i_wb_data[WIDTH-1:0];
                            sp_q <= sp_q + SPW'(1);
                        end
                    end
                    a_ien:    ien_q <= bus.i_wb_data[1:0];
                    peek_hit: mem[peek_idx] <= bus.i_wb_data[WIDTH-1:0];
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spell_stack.sv
// tb_spell_stack: directed scenarios plus randomized ops and wishbone
// traffic, checked each cycle against an array-and-count stack model.
module tb_spell_stack;
    localparam int WIDTH = 8;
    localparam int DL2   = 2;
    localparam int DEPTH = 1 << DL2;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    spell_stack_if #(.WIDTH(WIDTH), .DEPTH_LOG2(DL2)) bus ();

    spell_stack #(.WIDTH(WIDTH), .DEPTH_LOG2(DL2)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic check_en = 1'b0;

    logic [7:0]  m_mem [DEPTH];
    int          m_sp;
    logic [1:0]  m_intr, m_ien;
    logic        m_ack, m_err, m_prev;
    logic [31:0] m_rdata;

    logic [11:0] alist [14] = '{12'h000, 12'h004, 12'h008, 12'h00C,
                                12'h010, 12'h014, 12'h018, 12'h01C,
                                12'h100, 12'h104, 12'h108, 12'h10C,
                                12'h110, 12'h0FC};

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_top();
        return (m_sp > 0) ? m_mem[m_sp-1] : 8'h00;
    endfunction

    function automatic logic [7:0] m_below();
        return (m_sp > 1) ? m_mem[m_sp-2] : 8'h00;
    endfunction

    function automatic logic m_ready();
        logic req;
        req = bus.i_wb_cyc && bus.i_wb_stb;
        if (req && bus.i_wb_we) return 1'b0;
        if (req && !m_prev && bus.i_wb_addr[11:0] == 12'h00C) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int peek_slot(input logic [11:0] a);
`ifdef SPELL_STACK_PEEK_EN
        if (int'(a) >= 256 && int'(a) < 256 + 4*DEPTH && a[1:0] == 2'b00)
            return (int'(a) - 256) / 4;
`endif
        return -1;
    endfunction

    function automatic logic [31:0] m_rdval(input logic [11:0] a);
        int i;
        case (a)
            12'h000: return 32'(m_sp);
            12'h004, 12'h00C: return 32'(m_top());
            12'h010: return {m_sp == DEPTH, m_sp == 0, 30'(m_sp)};
            12'h014: return 32'(m_ien);
            12'h018: return 32'(m_intr);
            default: begin
                i = peek_slot(a);
                if (i >= 0 && i < m_sp) return 32'(m_mem[m_sp-1-i]);
                return 32'h0;
            end
        endcase
    endfunction

    // reference model: advances at every clock edge from the driven inputs
    always @(posedge clock) begin : model
        logic req, wr, rd, first, ready, e;
        logic [11:0] a;
        logic [1:0] set, clr;
        logic [31:0] d;
        int i, pop, push;
        req   = bus.i_wb_cyc && bus.i_wb_stb;
        wr    = req && bus.i_wb_we;
        rd    = req && !bus.i_wb_we;
        first = req && !m_prev;
        a     = bus.i_wb_addr[11:0];
        d     = bus.i_wb_data;
        pop   = int'(bus.op_pop);
        push  = int'(bus.op_push);
        if (!reset) begin
            for (int k = 0; k < DEPTH; k++) m_mem[k] = 8'h00;
            m_sp = 0; m_intr = 2'b00; m_ien = 2'b00;
            m_ack = 1'b0; m_err = 1'b0; m_prev = 1'b0; m_rdata = 32'h0;
        end else begin
            ready = m_ready();
            set = 2'b00; clr = 2'b00; e = 1'b0;
            if (rd && first) begin
                m_rdata = m_rdval(a);
                if (a == 12'h00C) begin
                    if (m_sp == 0) set[0] = 1'b1;
                    else m_sp--;
                end
            end
            if (bus.op_valid && ready) begin
                if (pop > m_sp) begin
                    set[0] = 1'b1; e = 1'b1;
                end else if (m_sp - pop + push > DEPTH) begin
                    set[1] = 1'b1; e = 1'b1;
                end else begin
                    m_sp = m_sp - pop;
                    if (push == 2) begin m_mem[m_sp] = bus.op_below; m_sp++; end
                    if (push >= 1) begin m_mem[m_sp] = bus.op_top; m_sp++; end
                end
            end
            if (wr) begin
                case (a)
                    12'h000: m_sp = (d > 32'(DEPTH)) ? DEPTH : int'(d);
                    12'h004: if (m_sp > 0) m_mem[m_sp-1] = d[7:0];
                    12'h008: begin
                        if (first) begin
                            if (m_sp == DEPTH) set[1] = 1'b1;
                            else begin m_mem[m_sp] = d[7:0]; m_sp++; end
                        end
                    end
                    12'h014: m_ien = d[1:0];
                    12'h018: clr = d[1:0];
                    default: begin
                        i = peek_slot(a);
                        if (i >= 0 && i < m_sp) m_mem[m_sp-1-i] = d[7:0];
                    end
                endcase
            end
            m_intr = (m_intr & ~clr) | set;
            m_err  = e;
            m_ack  = req;
            m_prev = req;
        end
    end

    // every-cycle comparison of all outputs against the model
    always @(negedge clock) begin
        if (check_en) begin
            chk("sp", 32'(bus.sp), 32'(m_sp));
            chk("top", 32'(bus.top), 32'(m_top()));
            chk("below", 32'(bus.below), 32'(m_below()));
            chk("op_error", 32'(bus.op_error), 32'(m_err));
            chk("ack", 32'(bus.o_wb_ack), 32'(m_ack));
            chk("rdata", bus.o_wb_data, m_rdata);
            chk("interrupt", 32'(bus.interrupt), 32'(|(m_intr & m_ien)));
            chk("op_ready", 32'(bus.op_ready), 32'(m_ready()));
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic idle();
        bus.op_valid = 1'b0; bus.op_pop = 2'd0; bus.op_push = 2'd0;
        bus.op_top = 8'h00; bus.op_below = 8'h00;
        bus.i_wb_cyc = 1'b0; bus.i_wb_stb = 1'b0; bus.i_wb_we = 1'b0;
        bus.i_wb_addr = 32'h0; bus.i_wb_data = 32'h0;
    endtask

    task automatic op(input logic [1:0] p, input logic [1:0] q,
                      input logic [7:0] t, input logic [7:0] b);
        bus.op_pop = p; bus.op_push = q; bus.op_top = t; bus.op_below = b;
        bus.op_valid = 1'b1;
        tick();
        bus.op_valid = 1'b0;
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
        bus.i_wb_cyc = 1'b1; bus.i_wb_stb = 1'b1; bus.i_wb_we = 1'b1;
        bus.i_wb_addr = a; bus.i_wb_data = d;
        tick();
        bus.i_wb_cyc = 1'b0; bus.i_wb_stb = 1'b0; bus.i_wb_we = 1'b0;
        tick();
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
        bus.i_wb_cyc = 1'b1; bus.i_wb_stb = 1'b1; bus.i_wb_we = 1'b0;
        bus.i_wb_addr = a;
        tick();
        bus.i_wb_cyc = 1'b0; bus.i_wb_stb = 1'b0;
        #1;
        d = bus.o_wb_data;
        tick();
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] a32;
        int r, k;
        idle();
        reset = 1'b0;
        repeat (3) tick();
        check_en = 1'b1;
        reset = 1'b1;
        #1;
        chk("rst_sp", 32'(bus.sp), 32'h0);
        chk("rst_top", 32'(bus.top), 32'h0);
        chk("rst_below", 32'(bus.below), 32'h0);
        chk("rst_err", 32'(bus.op_error), 32'h0);
        chk("rst_ack", 32'(bus.o_wb_ack), 32'h0);
        chk("rst_irq", 32'(bus.interrupt), 32'h0);
        tick();

        op(2'd0, 2'd2, 8'hAA, 8'h55);
        #1;
        chk("push2_sp", 32'(bus.sp), 32'd2);
        chk("push2_top", 32'(bus.top), 32'hAA);
        chk("push2_below", 32'(bus.below), 32'h55);
        chk("push2_err", 32'(bus.op_error), 32'h0);

        op(2'd1, 2'd0, 8'h00, 8'h00);
        op(2'd2, 2'd1, 8'h11, 8'h00);
        #1;
        chk("under_sp", 32'(bus.sp), 32'd1);
        chk("under_top", 32'(bus.top), 32'h55);
        chk("under_err", 32'(bus.op_error), 32'h1);
        wb_read(32'h018, d);
        chk("under_intr", d, 32'h1);
        wb_write(32'h014, 32'h1);
        #1;
        chk("irq_on", 32'(bus.interrupt), 32'h1);
        wb_write(32'h018, 32'h1);
        #1;
        chk("irq_clr", 32'(bus.interrupt), 32'h0);

        wb_write(32'h000, 32'h0);
        for (int v = 1; v <= 5; v++) wb_write(32'h008, 32'(v));
        #1;
        chk("ovf_sp", 32'(bus.sp), 32'd4);
        chk("ovf_top", 32'(bus.top), 32'h4);
        wb_read(32'h018, d);
        chk("ovf_intr", d, 32'h2);
        wb_read(32'h010, d);
        chk("status_full", d, 32'h8000_0004);

        wb_write(32'h018, 32'h3);
        wb_write(32'h000, 32'h2);
        bus.op_pop = 2'd0; bus.op_push = 2'd1; bus.op_top = 8'h77;
        bus.op_valid = 1'b1;
        bus.i_wb_cyc = 1'b1; bus.i_wb_stb = 1'b1; bus.i_wb_we = 1'b1;
        bus.i_wb_addr = 32'h008; bus.i_wb_data = 32'h33;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("hold_ready", 32'(bus.op_ready), 32'h0);
            tick();
        end
        bus.i_wb_cyc = 1'b0; bus.i_wb_stb = 1'b0; bus.i_wb_we = 1'b0;
        #1;
        chk("hold_sp", 32'(bus.sp), 32'd3);
        chk("hold_ready_up", 32'(bus.op_ready), 32'h1);
        tick();
        bus.op_valid = 1'b0;
        #1;
        chk("hold_op_sp", 32'(bus.sp), 32'd4);
        chk("hold_op_top", 32'(bus.top), 32'h77);
        chk("hold_op_below", 32'(bus.below), 32'h33);
        tick();

        wb_write(32'h000, 32'h2);
        op(2'd0, 2'd1, 8'h12, 8'h00);
        wb_read(32'h00C, d);
        chk("pop_data", d, 32'h12);
        chk("pop_sp", 32'(bus.sp), 32'd2);

        wb_write(32'h000, 32'h0);
        for (int v = 1; v <= 3; v++) wb_write(32'h008, 32'(v));
        wb_read(32'h104, d);
`ifdef SPELL_STACK_PEEK_EN
        chk("peek_104", d, 32'h2);
`else
        chk("peek_104", d, 32'h0);
`endif
        wb_read(32'h10C, d);
        chk("peek_10c", d, 32'h0);

        for (int it = 0; it < 1500; it++) begin
            idle();
            r = $urandom_range(0, 99);
            if (r < 2) begin
                reset = 1'b0;
                tick();
                reset = 1'b1;
            end else if (r < 60) begin
                bus.op_pop = 2'($urandom_range(0, 2));
                bus.op_push = 2'($urandom_range(0, 2));
                bus.op_top = 8'($urandom());
                bus.op_below = 8'($urandom());
                bus.op_valid = ($urandom_range(0, 3) != 0);
                tick();
            end else begin
                a32 = $urandom();
                a32[11:0] = alist[$urandom_range(0, 13)];
                d = $urandom();
                if (a32[11:0] == 12'h000 && $urandom_range(0, 3) != 0)
                    d = 32'($urandom_range(0, 6));
                bus.i_wb_cyc = 1'b1; bus.i_wb_stb = 1'b1;
                bus.i_wb_we = $urandom_range(0, 1) == 1;
                bus.i_wb_addr = a32; bus.i_wb_data = d;
                bus.op_pop = 2'($urandom_range(0, 2));
                bus.op_push = 2'($urandom_range(0, 2));
                bus.op_top = 8'($urandom());
                bus.op_valid = $urandom_range(0, 1) == 1;
                k = $urandom_range(1, 3);
                repeat (k) tick();
                bus.i_wb_cyc = 1'b0; bus.i_wb_stb = 1'b0; bus.i_wb_we = 1'b0;
                tick();
            end
        end
        idle();
        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/spell_stack.md
Name: spell_stack

Overview:
- Parametrised data stack for the next-generation spell core. Replaces the fixed 32x8 inline stack array.
- Configurable width and depth; tracks occupancy explicitly instead of letting the pointer wrap.
- Detects overflow and underflow, rejects the offending operation, and raises a maskable interrupt.
- Sits between the execute unit (op port) and the wishbone debug bus; exposes top and below-top to the executor and the logic analyzer.

Parameters:
- WIDTH, 8, data width of each stack entry.
- DEPTH_LOG2, 5, log2 of stack depth; DEPTH = 2**DEPTH_LOG2 entries.

Ports:
- clock  input  1  system clock, single domain.
- reset  input  1  synchronous, active-low reset.
- op_valid  input  1  executor presents a stack operation.
- op_ready  output  1  op accepted this cycle if op_valid; low when a wishbone write is active.
- op_pop  input  2  entries removed (0..2).
- op_push  input  2  entries added after the pop (0..2).
- op_top  input  WIDTH  value written to the new top when op_push>=1.
- op_below  input  WIDTH  value written to new top-1 when op_push==2.
- top  output  WIDTH  entry at sp-1; 0 when sp==0.
- below  output  WIDTH  entry at sp-2; 0 when sp<2.
- sp  output  DEPTH_LOG2+1  occupancy, 0..DEPTH.
- op_error  output  1  one-cycle pulse; the previous accepted op was rejected.
- i_wb_cyc, i_wb_stb, i_wb_we  input  1 each  wishbone control.
- i_wb_addr  input  32  byte address; bits [11:0] decoded.
- i_wb_data  input  32  write data.
- o_wb_ack  output  1  transaction acknowledge.
- o_wb_data  output  32  read data.
- interrupt  output  1  |(intr & intr_enable).

Behaviour:
- Reset (reset==0 at posedge):
  - sp=0; all entries cleared to 0.
  - intr=0, intr_enable=0.
  - o_wb_ack=0, o_wb_data=0, op_error=0.
  - Sets the outputs top=0, below=0, interrupt=0.
  - Reset mid-transaction drops the transaction; no ack is issued.
- Op acceptance: when op_valid && op_ready, compute n = sp - op_pop + op_push using DEPTH_LOG2+2-bit signed arithmetic.
  - Underflow: op_pop > sp. The op has no effect, intr[0]<=1, op_error pulses next cycle.
  - Overflow: n > DEPTH. The op has no effect, intr[1]<=1, op_error pulses next cycle.
  - Both conditions true: underflow takes precedence.
  - Otherwise: sp<=n; if op_push>=1, mem[n-1]<=op_top; if op_push==2, mem[n-2]<=op_below.
  - Results are visible on top, below and sp the next cycle. Throughput is one op per cycle.
- top and below are combinational reads of the storage at sp-1 and sp-2.
- Wishbone:
  - Reads: o_wb_data is registered and o_wb_ack asserts one cycle after stb&&cyc. Ack drops when stb drops.
  - Writes: take effect at the posedge where stb&&cyc&&we is high; ack follows one cycle later.
  - While a write is active, op_ready=0, so wishbone has priority over the executor.
- Register map (write / read):
  - 0x000 SP: write sets sp to min(data, DEPTH); read returns sp.
  - 0x004 TOP: write overwrites mem[sp-1] (ignored if sp==0); read returns top.
  - 0x008 PUSH: write, rising edge of write only; pushes data[WIDTH-1:0]; overflow sets intr[1], sp unchanged.
  - 0x00C POP: read returns top; sp decrements once per transaction (first cycle only). If sp==0, returns 0 and sets intr[0].
  - 0x010 STATUS: read only; returns {full, empty, sp}, with full at bit 31, empty at bit 30, sp in the low bits.
  - 0x014 INT_ENABLE: 2 bits, read/write.
  - 0x018 INT: write-1-to-clear; read returns intr.
  - Other addresses: reads return 0; writes are acked and ignored.
- intr bits are sticky. A set and a write-1-to-clear in the same cycle: the set wins.

Optional Feature:
- Macro: SPELL_STACK_PEEK_EN.
- Defined: addresses 0x100 + 4*i (i < DEPTH) read mem[sp-1-i] when i < sp, otherwise 0. Writes to the same window overwrite that entry when i < sp. Reads are acked with normal latency.
- Not defined: the window decodes as unmapped (reads return 0, writes ignored, ack still given).

Test Plan:
- Reset, then op push=2 with top=0xAA, below=0x55 -> next cycle sp=2, top=0xAA, below=0x55, op_error=0.
- sp=1, op pop=2 push=1 -> sp stays 1, intr=01, op_error pulses; with INT_ENABLE=1, interrupt=1; write INT=1 -> interrupt=0.
- DEPTH_LOG2=2, four PUSH writes of 1..4 then a fifth PUSH -> sp=4, intr[1]=1; STATUS reads 0x80000004.
- Hold a PUSH write stb for 3 cycles with op_valid=1 -> exactly one push; op_ready=0 during the write; the op is accepted the cycle after stb drops.
- POP read with sp=3, top=0x12 -> o_wb_data=0x12 one cycle after stb, sp=2.
- With SPELL_STACK_PEEK_EN, stack 1,2,3 pushed: read 0x104 -> 2; read 0x10C -> 0. Without the macro: read 0x104 -> 0.
